sb_rx_dispatcher: RTL and testbench

//  Read-side sequencer for the sideband receive FIFO. It polls the FIFO one message at a time

---
 rtl/sb_rx_dispatcher.sv | 148 ++++++++++++++
 tb/tb_sb_rx_dispatcher.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_rx_dispatcher.sv
// Sideband RX read sequencer: polls the RX FIFO one message at a time and hands each
// message to one of NUM_DEST valid/ready consumers. Illegal destinations and stalled consumers cause a drop.
module sb_rx_dispatcher #(
    parameter int NUM_DEST      = 4,
    parameter int DEST_LSB      = 0,
    parameter int POLL_GAP      = 8,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic                clk_100MHz,
    input  logic                reset,
    input  logic                enable_i,
    output logic                rx_msg_req_o,
    input  logic [63:0]         rx_data_i,
    input  logic                rx_valid_i,
    output logic [NUM_DEST-1:0] dst_valid_o,
    output logic [63:0]         dst_data_o,
    input  logic [NUM_DEST-1:0] dst_ready_i,
    output logic                drop_o,
    output logic [7:0]          drop_cnt_o,
    output logic                busy_o
);

    localparam int DW = $clog2(NUM_DEST);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, BACKOFF} state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       dest_q, dest_d;
    logic [7:0]          stall_q, stall_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [63:0]         data_q, data_d;
    logic                req_q, req_d;
    logic [NUM_DEST-1:0] valid_q, valid_d;
    logic                drop_q, drop_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic                busy_q, busy_d;

    logic                drop_evt;
    logic [DW-1:0]       rx_dest;
    logic                rx_dest_ok;
    logic [2**DW-1:0]    ready_pad;
    logic [NUM_DEST-1:0] hold_sel;

    assign rx_dest    = rx_data_i[DEST_LSB +: DW];
    assign rx_dest_ok = (int'(rx_dest) < NUM_DEST);
    // Padding lets a non-power-of-2 consumer count be indexed by the full dest field.
    assign ready_pad  = (2**DW)'(dst_ready_i);

    generate
        for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_sel
            assign hold_sel[gi] = (state_d == HOLD) && (dest_d == DW'(gi));
        end
    endgenerate

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dest_q     <= '0;
            stall_q    <= '0;
            gap_q      <= '0;
            data_q     <= '0;
            req_q      <= 1'b0;
            valid_q    <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            stall_q    <= stall_d;
            gap_q      <= gap_d;
            data_q     <= data_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        stall_d  = stall_q;
        gap_d    = gap_q;
        data_d   = data_q;
        drop_evt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i) state_d = REQ;
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (rx_valid_i) begin
                    data_d = rx_data_i;
                    if (rx_dest_ok) begin
                        state_d = HOLD;
                        dest_d  = rx_dest;
                        stall_d = '0;
                    end else begin
                        state_d  = IDLE;
                        drop_evt = 1'b1;
                    end
                end else begin
                    state_d = BACKOFF;
                    gap_d   = GW'(POLL_GAP - 1);
                end
            end
            BACKOFF: begin
                if (gap_q == '0) state_d = IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            HOLD: begin
                // Ready in the final timeout cycle still wins over the drop.
                if (ready_pad[dest_q]) begin
                    state_d = IDLE;
                end else begin
                    stall_d = stall_q + 8'd1;
                    if (stall_q + 8'd1 == 8'(STALL_TIMEOUT)) begin
                        state_d  = IDLE;
                        drop_evt = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_d      = (state_d == REQ);
        busy_d     = (state_d != IDLE);
        valid_d    = hold_sel;
        drop_d     = drop_evt;
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    assign rx_msg_req_o = req_q;
    assign dst_valid_o  = valid_q;
    assign dst_data_o   = data_q;
    assign drop_o       = drop_q;
    assign drop_cnt_o   = drop_cnt_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_sb_rx_dispatcher.sv
// Bench for sb_rx_dispatcher with three consumers: FIFO model, scoreboard of
// expected deliveries and directed timing checks.
module tb_sb_rx_dispatcher;

    logic        clk_100MHz = 1'b0;
    logic        reset      = 1'b1;
    logic        enable_i   = 1'b0;
    logic        rx_msg_req_o;
    logic [63:0] rx_data_i  = '0;
    logic        rx_valid_i = 1'b0;
    logic [2:0]  dst_valid_o;
    logic [63:0] dst_data_o;
    logic [2:0]  dst_ready_i = '0;
    logic        drop_o;
    logic [7:0]  drop_cnt_o;
    logic        busy_o;

    sb_rx_dispatcher #(
        .NUM_DEST(3), .DEST_LSB(0), .POLL_GAP(8), .STALL_TIMEOUT(255)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .enable_i    (enable_i),
        .rx_msg_req_o(rx_msg_req_o),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .dst_valid_o (dst_valid_o),
        .dst_data_o  (dst_data_o),
        .dst_ready_i (dst_ready_i),
        .drop_o      (drop_o),
        .drop_cnt_o  (drop_cnt_o),
        .busy_o      (busy_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  vld;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] fifo_q[$];
    int          xfer_t[$];
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          cyc        = 0;
    int          drop_seen  = 0;
    int          exp_drops  = 0;
    bit          pending_req = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int sat_drops();
        return (exp_drops > 255) ? 255 : exp_drops;
    endfunction

    task automatic push_msg(input logic [63:0] d, input bit deliver);
        exp_t e;
        fifo_q.push_back(d);
        if (deliver) begin
            e.data = d;
            e.vld  = 3'(1 << d[1:0]);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (dst_valid_o != '0) return;
            @(negedge clk_100MHz);
        end
        chk(tag, 0, 1);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (rx_msg_req_o) return;
            @(negedge clk_100MHz);
        end
        chk(tag, 0, 1);
    endtask

    always @(posedge clk_100MHz) cyc <= cyc + 1;

    // FIFO model: data answers one cycle after the request cycle when non-empty.
    always begin
        @(posedge clk_100MHz);
        #1;
        rx_valid_i = 1'b0;
        if (pending_req && fifo_q.size() > 0) begin
            rx_data_i  = fifo_q.pop_front();
            rx_valid_i = 1'b1;
        end
        pending_req = rx_msg_req_o;
    end

    // Consumer monitor: a transfer is any cycle with valid and ready on the same bit.
    always begin
        exp_t e;
        @(negedge clk_100MHz);
        #1;
        if (!reset) begin
            if (drop_o) drop_seen++;
            if (|(dst_valid_o & dst_ready_i)) begin
                xfer_t.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", dst_data_o, e.data);
                    chk("sb_dest", 64'(dst_valid_o), 64'(e.vld));
                end
            end
        end
    end

    initial begin
        int n;
        int n_bad;
        logic [63:0] d;

        #1;
        chk("rst_req",   rx_msg_req_o, 0);
        chk("rst_valid", dst_valid_o, 0);
        chk("rst_data",  dst_data_o, 0);
        chk("rst_drop",  drop_o, 0);
        chk("rst_cnt",   drop_cnt_o, 0);
        chk("rst_busy",  busy_o, 0);
        repeat (3) @(negedge clk_100MHz);
        reset = 1'b0;
        @(negedge clk_100MHz);

        // Test 1: single message to consumer 2, latency and single request pulse
        push_msg(64'h0000_0000_0000_0002, 1);
        dst_ready_i = 3'b100;
        enable_i    = 1'b1;
        @(negedge clk_100MHz);
        chk("t1_req_pulse", rx_msg_req_o, 1);
        @(negedge clk_100MHz);
        chk("t1_req_single", rx_msg_req_o, 0);
        chk("t1_valid_early", dst_valid_o, 0);
        @(negedge clk_100MHz);
        chk("t1_valid", dst_valid_o, 3'b100);
        chk("t1_data", dst_data_o, 64'h2);
        chk("t1_busy", busy_o, 1);
        chk("t1_cnt", drop_cnt_o, 0);
        @(negedge clk_100MHz);
        chk("t1_valid_1cyc", dst_valid_o, 0);

        // Test 2: empty FIFO polling period
        n_bad = 0;
        for (int k = 0; k < 2; k++) begin
            wait_req("t2_req_timeout");
            n = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk_100MHz);
                n++;
                if (dst_valid_o != '0) n_bad++;
                if (rx_msg_req_o) break;
            end
            chk("t2_poll_period", n, 11);
        end
        chk("t2_no_valid", n_bad, 0);

        // Test 3: illegal destination (3 with three consumers) is dropped, then polling resumes
        push_msg(64'hDEAD_BEEF_0000_0003, 0);
        exp_drops++;
        n = 0;
        while (!drop_o && n < 40) begin
            @(negedge clk_100MHz);
            n++;
        end
        chk("t3_drop_pulse", drop_o, 1);
        chk("t3_cnt", drop_cnt_o, 64'(sat_drops()));
        chk("t3_no_valid", dst_valid_o, 0);
        @(negedge clk_100MHz);
        chk("t3_poll_after", rx_msg_req_o, 1);
        chk("t3_drop_1cyc", drop_o, 0);
        chk("t3_drop_seen", drop_seen, 1);

        // Test 4a: consumer 1 never ready -> timeout drop after 255 HOLD cycles
        dst_ready_i = 3'b000;
        push_msg(64'h1234_5678_9ABC_DE01, 0);
        exp_drops++;
        wait_valid("t4a_valid_timeout");
        chk("t4a_valid", dst_valid_o, 3'b010);
        n = 1;
        while (dst_valid_o != '0 && n < 400) begin
            @(negedge clk_100MHz);
            if (dst_valid_o != '0) n++;
        end
        chk("t4a_hold_cycles", n, 255);
        chk("t4a_drop", drop_o, 1);
        chk("t4a_cnt", drop_cnt_o, 64'(sat_drops()));

        // Test 4b: ready arrives in the timeout cycle -> delivered, no drop
        push_msg(64'hCAFE_0000_1111_2221, 1);
        wait_valid("t4b_valid_timeout");
        repeat (254) @(negedge clk_100MHz);
        chk("t4b_still_held", dst_valid_o, 3'b010);
        dst_ready_i = 3'b010;
        @(negedge clk_100MHz);
        dst_ready_i = 3'b000;
        chk("t4b_released", dst_valid_o, 0);
        chk("t4b_no_drop", drop_o, 0);
        chk("t4b_cnt", drop_cnt_o, 64'(sat_drops()));

        // Test 5a: enable drop during HOLD does not abort delivery, and stops polling
        push_msg(64'h0F0F_0F0F_0F0F_0F00, 1);
        wait_valid("t5a_valid_timeout");
        enable_i = 1'b0;
        repeat (5) @(negedge clk_100MHz);
        chk("t5a_held", dst_valid_o, 3'b001);
        dst_ready_i = 3'b001;
        @(negedge clk_100MHz);
        dst_ready_i = 3'b000;
        chk("t5a_delivered", dst_valid_o, 0);
        chk("t5a_idle", busy_o, 0);
        n = 0;
        repeat (30) begin
            @(negedge clk_100MHz);
            if (rx_msg_req_o) n++;
        end
        chk("t5a_no_req", n, 0);

        // Test 5b: asynchronous reset while holding a message
        push_msg(64'h5555_AAAA_5555_AAA2, 0);
        enable_i = 1'b1;
        wait_valid("t5b_valid_timeout");
        enable_i = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t5b_valid", dst_valid_o, 0);
        chk("t5b_data", dst_data_o, 0);
        chk("t5b_busy", busy_o, 0);
        chk("t5b_cnt", drop_cnt_o, 0);
        chk("t5b_req", rx_msg_req_o, 0);
        chk("t5b_drop", drop_o, 0);
        exp_drops = 0;
        drop_seen = 0;
        @(negedge clk_100MHz);
        reset = 1'b0;
        @(negedge clk_100MHz);

        // Test 6a: 300 illegal messages saturate the drop counter
        enable_i    = 1'b1;
        dst_ready_i = 3'b111;
        for (int i = 0; i < 300; i++) begin
            d = {$urandom, $urandom};
            d[1:0] = 2'b11;
            push_msg(d, 0);
        end
        exp_drops += 300;
        n = 0;
        while (fifo_q.size() > 0 && n < 2000) begin
            @(negedge clk_100MHz);
            n++;
        end
        chk("t6a_fifo_drained", fifo_q.size(), 0);
        repeat (5) @(negedge clk_100MHz);
        chk("t6a_cnt_sat", drop_cnt_o, 64'(sat_drops()));
        chk("t6a_drop_pulses", drop_seen, 300);

        // Test 6b: back-to-back deliveries 4 cycles apart, in order
        xfer_t.delete();
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom};
            d[1:0] = 2'(i % 3);
            push_msg(d, 1);
        end
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk_100MHz);
            n++;
        end
        #2;
        chk("t6b_all_delivered", xfer_t.size(), 8);
        for (int i = 1; i < xfer_t.size(); i++)
            chk("t6b_spacing", xfer_t[i] - xfer_t[i-1], 4);
        chk("t6b_cnt_hold", drop_cnt_o, 8'hFF);

        repeat (3) @(negedge clk_100MHz);
        chk("end_sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
